xbar_scheduler: RTL and testbench

Sequential scheduler for the 4x4 router crossbar: accepts per-input packet requests (destination output plus flit count), arbitrates each output port round-robin among contending inputs, and holds the crossbar path for the full packet. Each output gets a 2-bit input select and an enable, the same select-plus-enable pair the crossbar switch consumes. Each winning input gets a grant. It sits between the input FIFOs and the crossbar, and replaces static CNFG/LOAD path configuration with dynamic per-packet scheduling.

---
 rtl/xbar_scheduler.sv | 117 +++++++++++
 tb/tb_xbar_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : xbar_scheduler
// Description : Per-packet scheduler for a 4x4 crossbar. Each output runs a
//               two-state FSM with a round-robin pointer and a flit counter.
//               It grants a requesting input, then holds the path until the
//               packet's last flit has been transferred.
// Revision    : 1.0 - initial release
// ============================================================================
module xbar_scheduler #(
   parameter int LEN_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         req,
   input  logic [7:0]         dest,
   input  logic [4*LEN_W-1:0] len,
   input  logic [3:0]         flit_valid,
   output logic [3:0]         gnt,
   output logic [7:0]         sel,
   output logic [3:0]         oen,
   output logic [3:0]         busy
);

   localparam logic [0:0]       c_IDLE = 1'b0;
   localparam logic [0:0]       c_BUSY = 1'b1;
   localparam logic [LEN_W-1:0] c_ONE  = LEN_W'(1);

   logic [3:0] w_busy;
   logic [7:0] w_sel;

   // An input owns a path while any busy output selects it. This is
   // derived only from registers, so there is no input-to-output path.
   always_comb begin
      gnt = '0;
      for (int o = 0; o < 4; o++) begin
         if (w_busy[o]) begin
            gnt[w_sel[2*o +: 2]] = 1'b1;
         end
      end
   end

   genvar go;
   generate
      for (go = 0; go < 4; go++) begin : g_out
         logic [0:0]       r_state;
         logic [1:0]       r_ptr;
         logic [1:0]       r_sel;
         logic [LEN_W-1:0] r_cnt;
         logic [3:0]       w_cand;
         logic             w_found;
         logic [1:0]       w_pick;
         logic [LEN_W-1:0] w_pick_len;
         logic             w_flit;

         // Candidate set and round-robin pick.
         // The scan starts at the pointer; the lowest offset wins.
         always_comb begin
            w_cand  = '0;
            w_found = 1'b0;
            w_pick  = r_ptr;
            for (int i = 0; i < 4; i++) begin
               w_cand[i] = req[i] && (dest[2*i +: 2] == 2'(go)) && !gnt[i];
            end
            for (int k = 3; k >= 0; k--) begin
               if (w_cand[r_ptr + 2'(k)]) begin
                  w_found = 1'b1;
                  w_pick  = r_ptr + 2'(k);
               end
            end
            w_pick_len = len[LEN_W*w_pick +: LEN_W];
            w_flit     = flit_valid[r_sel];
         end

         // Per-output FSM.
         // It picks in IDLE and counts flits in BUSY. On release it moves
         // the pointer past the last winner; sel keeps its last value.
         always_ff @(posedge clk) begin
            if (reset) begin
               r_state <= c_IDLE;
               r_ptr   <= '0;
               r_sel   <= '0;
               r_cnt   <= '0;
            end else begin
               case (r_state)
                  c_IDLE: begin
                     if (w_found) begin
                        r_state <= c_BUSY;
                        r_sel   <= w_pick;
                        r_cnt   <= (w_pick_len == '0) ? c_ONE : w_pick_len;
                     end
                  end
                  c_BUSY: begin
                     if (w_flit) begin
                        r_cnt <= r_cnt - c_ONE;
                        if (r_cnt == c_ONE) begin
                           r_state <= c_IDLE;
                           r_ptr   <= r_sel + 2'd1;
                        end
                     end
                  end
                  default: r_state <= c_IDLE;
               endcase
            end
         end

         assign w_busy[go]        = (r_state == c_BUSY);
         assign w_sel[2*go +: 2]  = r_sel;
      end
   endgenerate

   assign sel  = w_sel;
   assign oen  = w_busy;
   assign busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_xbar_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_xbar_scheduler
// Description : Self-checking bench for xbar_scheduler. It compares the
//               design against a packet-level reference model and against
//               hand-derived scenario values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xbar_scheduler;
   localparam int LEN_W = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic [3:0]         req;
   logic [7:0]         dest;
   logic [4*LEN_W-1:0] len;
   logic [3:0]         flit_valid;
   logic [3:0]         gnt;
   logic [7:0]         sel;
   logic [3:0]         oen;
   logic [3:0]         busy;

   int total = 0;
   int bad   = 0;

   xbar_scheduler #(.LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset), .req(req), .dest(dest), .len(len),
      .flit_valid(flit_valid), .gnt(gnt), .sel(sel), .oen(oen), .busy(busy)
   );

   always #5 clk = ~clk;

   // Packet-level model: per output, the owner, the flits remaining and the
   // next input in line for priority.
   bit m_busy [4];
   int m_owner[4];
   int m_rem  [4];
   int m_ptr  [4];

   function automatic logic [3:0] m_gnt();
      logic [3:0] g = '0;
      for (int o = 0; o < 4; o++) if (m_busy[o]) g[m_owner[o]] = 1'b1;
      return g;
   endfunction

   function automatic logic [7:0] m_sel();
      logic [7:0] s = '0;
      for (int o = 0; o < 4; o++) s[2*o +: 2] = 2'(m_owner[o]);
      return s;
   endfunction

   function automatic logic [3:0] m_oen();
      logic [3:0] e = '0;
      for (int o = 0; o < 4; o++) e[o] = m_busy[o];
      return e;
   endfunction

   task automatic model_edge();
      logic [3:0] g;
      int best, bestd, d, l;
      g = m_gnt();
      for (int o = 0; o < 4; o++) begin
         if (reset) begin
            m_busy[o] = 0; m_owner[o] = 0; m_rem[o] = 0; m_ptr[o] = 0;
         end else if (m_busy[o]) begin
            if (flit_valid[m_owner[o]]) begin
               m_rem[o]--;
               if (m_rem[o] == 0) begin
                  m_busy[o] = 0;
                  m_ptr[o]  = (m_owner[o] + 1) % 4;
               end
            end
         end else begin
            best = -1; bestd = 99;
            for (int i = 0; i < 4; i++) begin
               if (req[i] && dest[2*i +: 2] == 2'(o) && !g[i]) begin
                  d = (i - m_ptr[o] + 4) % 4;
                  if (d < bestd) begin bestd = d; best = i; end
               end
            end
            if (best >= 0) begin
               l = int'(len[LEN_W*best +: LEN_W]);
               m_busy[o] = 1; m_owner[o] = best; m_rem[o] = (l == 0) ? 1 : l;
            end
         end
      end
   endtask

   // One clock: advance the model with the inputs present before the edge,
   // then let the outputs settle a moment after the edge.
   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_all();
      reset = 1'b1; req = '0; dest = '0; len = '0; flit_valid = '0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req = 4'hF; dest = 8'h00; len = '1; flit_valid = 4'hF;
      tick(); tick();
      total++; if (gnt !== 4'b0)  begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
      total++; if (sel !== 8'b0)  begin bad++; $display("FAIL reset_sel got=%b want=00000000", sel); end
      total++; if (oen !== 4'b0 || busy !== 4'b0) begin bad++; $display("FAIL reset_oen got=%b/%b want=0000", oen, busy); end
      reset = 1'b0; req = '0; flit_valid = '0;
   endtask

   task automatic test_single();
      clear_all();
      req = 4'b0010; dest = 8'b00_00_10_00; len = 16'h0030; flit_valid = 4'b0010;
      tick();
      req = '0;
      total++; if (gnt !== 4'b0010 || sel[5:4] !== 2'd1) begin bad++; $display("FAIL single_grant gnt=%b sel2=%0d want 0010/1", gnt, sel[5:4]); end
      for (int k = 0; k < 3; k++) begin
         total++; if (oen !== 4'b0100) begin bad++; $display("FAIL single_hold cyc=%0d oen=%b want=0100", k, oen); end
         tick();
      end
      total++; if (gnt !== 4'b0 || oen !== 4'b0) begin bad++; $display("FAIL single_release gnt=%b oen=%b want 0", gnt, oen); end
   endtask

   task automatic test_contention();
      logic [3:0] exp_g [7];
      exp_g = '{4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0001};
      clear_all();
      req = 4'b0101; dest = 8'h00; len = 16'h0202; flit_valid = 4'hF;
      for (int k = 0; k < 7; k++) begin
         tick();
         total++; if (gnt !== exp_g[k]) begin bad++; $display("FAIL contention cyc=%0d gnt=%b want=%b", k, gnt, exp_g[k]); end
         total++; if ({gnt, sel, oen} !== {m_gnt(), m_sel(), m_oen()}) begin bad++; $display("FAIL contention_model cyc=%0d got=%b/%b/%b want=%b/%b/%b", k, gnt, sel, oen, m_gnt(), m_sel(), m_oen()); end
      end
   endtask

   task automatic test_parallel();
      clear_all();
      req = 4'hF; dest = 8'b00_01_10_11; len = 16'h1111; flit_valid = 4'hF;
      tick();
      req = '0;
      total++; if (gnt !== 4'hF || oen !== 4'hF) begin bad++; $display("FAIL parallel_grant gnt=%b oen=%b want 1111", gnt, oen); end
      total++; if (sel !== 8'b00_01_10_11) begin bad++; $display("FAIL parallel_sel got=%b want=00011011", sel); end
      tick();
      total++; if (gnt !== 4'h0 || oen !== 4'h0) begin bad++; $display("FAIL parallel_release gnt=%b oen=%b want 0", gnt, oen); end
   endtask

   task automatic test_len_edge();
      int held;
      clear_all();
      req = 4'b0001; dest = 8'h02; len = 16'h0000; flit_valid = 4'b0001;
      tick();
      req = '0;
      total++; if (oen !== 4'b0100) begin bad++; $display("FAIL len0_grant oen=%b want=0100", oen); end
      tick();
      total++; if (oen !== 4'b0000) begin bad++; $display("FAIL len0_release oen=%b want=0000", oen); end
      clear_all();
      req = 4'b0001; dest = 8'h00; len = 16'h000F; flit_valid = '0;
      tick();
      req = '0; held = 0;
      for (int k = 0; k < 60 && gnt[0]; k++) begin
         flit_valid[0] = k[0];
         held++;
         tick();
      end
      flit_valid = '0;
      total++; if (held != 30) begin bad++; $display("FAIL len15_toggle held=%0d want=30", held); end
   endtask

   task automatic test_withdraw();
      clear_all();
      req = 4'b0001; dest = 8'h01; len = 16'h0003; flit_valid = '0;
      tick();
      req = '0; flit_valid = 4'b1000;
      for (int k = 0; k < 4; k++) tick();
      total++; if (gnt !== 4'b0001 || oen !== 4'b0010) begin bad++; $display("FAIL withdraw_hold gnt=%b oen=%b want 0001/0010", gnt, oen); end
      flit_valid = 4'b1001;
      tick(); tick();
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL withdraw_count gnt=%b want=0001", gnt); end
      tick();
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL withdraw_release gnt=%b want=0000", gnt); end
      flit_valid = '0;
   endtask

   task automatic test_reset_mid();
      clear_all();
      req = 4'b0001; dest = 8'b00_00_01_01; len = 16'h0081; flit_valid = 4'b0011;
      tick();
      req = 4'b0010;
      tick();
      tick();
      total++; if (gnt !== 4'b0010 || sel[3:2] !== 2'd1) begin bad++; $display("FAIL mid_setup gnt=%b sel1=%0d want 0010/1", gnt, sel[3:2]); end
      for (int k = 0; k < 3; k++) tick();
      req = 4'b0011; flit_valid = '0; reset = 1'b1;
      tick();
      total++; if (gnt !== 4'b0 || oen !== 4'b0 || sel !== 8'b0) begin bad++; $display("FAIL mid_reset gnt=%b oen=%b sel=%b want 0", gnt, oen, sel); end
      reset = 1'b0;
      tick();
      total++; if (gnt !== 4'b0001 || oen !== 4'b0010 || sel[3:2] !== 2'd0) begin bad++; $display("FAIL mid_regrant gnt=%b oen=%b sel1=%0d want 0001/0010/0", gnt, oen, sel[3:2]); end
      total++; if ({gnt, sel, oen} !== {m_gnt(), m_sel(), m_oen()}) begin bad++; $display("FAIL mid_model got=%b/%b/%b want=%b/%b/%b", gnt, sel, oen, m_gnt(), m_sel(), m_oen()); end
   endtask

   task automatic test_random();
      clear_all();
      for (int k = 0; k < 600; k++) begin
         reset = ($urandom_range(0, 149) == 0);
         req   = 4'($urandom);
         dest  = 8'($urandom);
         for (int i = 0; i < 4; i++) len[LEN_W*i +: LEN_W] = LEN_W'($urandom_range(0, 4));
         flit_valid = 4'($urandom);
         tick();
         total++; if ({gnt, sel, oen, busy} !== {m_gnt(), m_sel(), m_oen(), m_oen()}) begin bad++; $display("FAIL random cyc=%0d got gnt=%b sel=%b oen=%b busy=%b want gnt=%b sel=%b oen=%b", k, gnt, sel, oen, busy, m_gnt(), m_sel(), m_oen()); end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; req = '0; dest = '0; len = '0; flit_valid = '0;
      test_reset();
      test_single();
      test_contention();
      test_parallel();
      test_len_edge();
      test_withdraw();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
